uncache_mem_ctrl: RTL and testbench

- Memory-side slave for the LSU uncached request/response channel. Sits directly downstream of the LSU.
- Accepts one request at a time. Converts the byte address and size into a doubleword-indexed SRAM access with byte strobes.
- Stores: lane-shifts write data. Loads: returns read data right-aligned, upper bits zero.
- Adds programmable access latency to model slow uncached devices.

---
 rtl/uncache_mem_if.sv | 34 +++
 rtl/uncache_mem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_uncache_mem_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uncache_mem_if.sv
// uncache_mem_if: LSU uncached request/response channel between the LSU (master) and memory (slave).
// The error output exists only when UNCACHE_MISALIGN_CHK_EN is defined.
interface uncache_mem_if;
  logic        uncache_mem_vld_i;
  logic        uncache_mem_ready_o;
  logic        uncache_mem_write_i;
  logic [2:0]  uncache_mem_size_i;
  logic [63:0] uncache_mem_addr_i;
  logic [63:0] uncache_mem_wdata_i;
  logic        uncache_mem_resp_vld_o;
  logic        uncache_mem_resp_rdy_i;
  logic [63:0] uncache_mem_resp_data_o;
`ifdef UNCACHE_MISALIGN_CHK_EN
  logic        uncache_mem_err_o;
`endif

  modport slave (
    input  uncache_mem_vld_i, uncache_mem_write_i, uncache_mem_size_i, uncache_mem_addr_i,
           uncache_mem_wdata_i, uncache_mem_resp_rdy_i,
    output uncache_mem_ready_o, uncache_mem_resp_vld_o, uncache_mem_resp_data_o
`ifdef UNCACHE_MISALIGN_CHK_EN
    , output uncache_mem_err_o
`endif
  );

  modport master (
    output uncache_mem_vld_i, uncache_mem_write_i, uncache_mem_size_i, uncache_mem_addr_i,
           uncache_mem_wdata_i, uncache_mem_resp_rdy_i,
    input  uncache_mem_ready_o, uncache_mem_resp_vld_o, uncache_mem_resp_data_o
`ifdef UNCACHE_MISALIGN_CHK_EN
    , input uncache_mem_err_o
`endif
  );
endinterface

// File: rtl/uncache_mem_ctrl.sv
// uncache_mem_ctrl: single-outstanding uncached LSU slave driving a 64-bit SRAM with added latency.
// Define UNCACHE_MISALIGN_CHK_EN to reject misaligned accesses and report them on uncache_mem_err_o.
module uncache_mem_ctrl #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  uncache_mem_if.slave      lsu,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [7:0]        sram_wstrb_o,
  output logic [63:0]       sram_wdata_o,
  input  logic [63:0]       sram_rdata_i
);

  localparam logic [3:0] Lat = 4'(LATENCY);

  typedef enum logic [2:0] {StIdle, StWait, StAccess, StRdata, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              resp_vld_q, resp_vld_d;
  logic [63:0]       resp_data_q, resp_data_d;
  logic              sram_en_q, sram_en_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [7:0]        sram_wstrb_q, sram_wstrb_d;
  logic [63:0]       sram_wdata_q, sram_wdata_d;

  // Size bit 2 only selects sign extension in the LSU.
  logic unused_size_msb;
  assign unused_size_msb = lsu.uncache_mem_size_i[2];

  logic [63:0]       offs;
  logic [2:0]        off;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic [7:0]        base_mask;
  logic [63:0]       size_mask;
  logic [7:0]        lane_strb;
  logic [63:0]       lane_wdata;
  logic [63:0]       rdata_aligned;
  logic              misaligned;

  assign offs     = addr_q - BASE_ADDR;
  assign off      = offs[2:0];
  assign idx      = offs[ADDR_W+2:3];
  assign in_range = (addr_q >= BASE_ADDR) && (offs < (64'd8 << ADDR_W));

  always_comb begin
    unique case (size_q)
      2'd0: begin base_mask = 8'h01; size_mask = 64'h0000_0000_0000_00ff; end
      2'd1: begin base_mask = 8'h03; size_mask = 64'h0000_0000_0000_ffff; end
      2'd2: begin base_mask = 8'h0f; size_mask = 64'h0000_0000_ffff_ffff; end
      default: begin base_mask = 8'hff; size_mask = 64'hffff_ffff_ffff_ffff; end
    endcase
  end

  // Strobes shifted past byte 7 fall off the 8-bit result rather than wrapping.
  assign lane_strb     = base_mask << off;
  assign lane_wdata    = wdata_q << {off, 3'b000};
  assign rdata_aligned = (sram_rdata_i >> {off, 3'b000}) & size_mask;

`ifdef UNCACHE_MISALIGN_CHK_EN
  always_comb begin
    unique case (size_q)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end

  assign lsu.uncache_mem_err_o = misaligned &&
                                 (((state_q == StAccess) && write_q) || (state_q == StResp));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_vld_d   = resp_vld_q;
    resp_data_d  = resp_data_q;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wstrb_d = sram_wstrb_q;
    sram_wdata_d = sram_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (lsu.uncache_mem_vld_i) begin
          write_d = lsu.uncache_mem_write_i;
          size_d  = lsu.uncache_mem_size_i[1:0];
          addr_d  = lsu.uncache_mem_addr_i;
          wdata_d = lsu.uncache_mem_wdata_i;
          cnt_d   = Lat;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (write_q && !in_range && !misaligned) begin
          state_d = StIdle;
        end else begin
          state_d = StAccess;
          // Loads that are rejected still walk ACCESS/RDATA so their timing matches a real read.
          if (in_range && !misaligned) begin
            sram_en_d   = 1'b1;
            sram_we_d   = write_q;
            sram_addr_d = idx;
            if (write_q) begin
              sram_wstrb_d = lane_strb;
              sram_wdata_d = lane_wdata;
            end else begin
              sram_wstrb_d = 8'h00;
            end
          end
        end
      end
      StAccess: state_d = write_q ? StIdle : StRdata;
      StRdata: begin
        if (misaligned) begin
          resp_data_d = '1;
        end else if (in_range) begin
          resp_data_d = rdata_aligned;
        end else begin
          resp_data_d = '0;
        end
        resp_vld_d = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        if (lsu.uncache_mem_resp_rdy_i) begin
          resp_vld_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_vld_q   <= 1'b0;
      resp_data_q  <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wstrb_q <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_vld_q   <= resp_vld_d;
      resp_data_q  <= resp_data_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wstrb_q <= sram_wstrb_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign lsu.uncache_mem_ready_o     = (state_q == StIdle);
  assign lsu.uncache_mem_resp_vld_o  = resp_vld_q;
  assign lsu.uncache_mem_resp_data_o = resp_data_q;
  assign sram_en_o                   = sram_en_q;
  assign sram_we_o                   = sram_we_q;
  assign sram_addr_o                 = sram_addr_q;
  assign sram_wstrb_o                = sram_wstrb_q;
  assign sram_wdata_o                = sram_wdata_q;

endmodule

// File: tb/tb_uncache_mem_ctrl.sv
// tb_uncache_mem_ctrl: randomized bench for uncache_mem_ctrl against a byte-level memory model.
// Instance a uses LATENCY=2, instance b uses LATENCY=0 for the back-to-back store case.
module tb_uncache_mem_ctrl;
  localparam int unsigned AW    = 6;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LAT_A = 2;
  localparam int          SPAN  = 8 << AW;
  localparam int          WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cmps = 0;
  int errs = 0;

  uncache_mem_if a_if ();
  uncache_mem_if b_if ();

  logic          sa_en, sa_we, sb_en, sb_we;
  logic [AW-1:0] sa_addr, sb_addr;
  logic [7:0]    sa_wstrb, sb_wstrb;
  logic [63:0]   sa_wdata, sb_wdata;
  logic [63:0]   sa_rdata = '0;
  logic [63:0]   sb_rdata = '0;

  uncache_mem_ctrl #(.ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .lsu(a_if), .sram_en_o(sa_en), .sram_we_o(sa_we),
    .sram_addr_o(sa_addr), .sram_wstrb_o(sa_wstrb), .sram_wdata_o(sa_wdata),
    .sram_rdata_i(sa_rdata)
  );

  uncache_mem_ctrl #(.ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .lsu(b_if), .sram_en_o(sb_en), .sram_we_o(sb_we),
    .sram_addr_o(sb_addr), .sram_wstrb_o(sb_wstrb), .sram_wdata_o(sb_wdata),
    .sram_rdata_i(sb_rdata)
  );

  // SRAM models with a backdoor preload port; ref_a is the byte-level expectation for instance a.
  logic [63:0]   mem_a [WORDS];
  logic [63:0]   mem_b [WORDS];
  logic [7:0]    ref_a [SPAN];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_idx = '0;
  logic [63:0]   bd_val = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem_a[bd_idx] = bd_val;
      mem_b[bd_idx] = bd_val;
    end
    if (sa_en) begin
      if (sa_we) begin
        for (int i = 0; i < 8; i++) if (sa_wstrb[i]) mem_a[sa_addr][i*8 +: 8] = sa_wdata[i*8 +: 8];
      end else begin
        sa_rdata = mem_a[sa_addr];
      end
    end
    if (sb_en) begin
      if (sb_we) begin
        for (int i = 0; i < 8; i++) if (sb_wstrb[i]) mem_b[sb_addr][i*8 +: 8] = sb_wdata[i*8 +: 8];
      end else begin
        sb_rdata = mem_b[sb_addr];
      end
    end
  end

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(SPAN));
  endfunction

  function automatic bit is_mis(input logic [2:0] sz, input logic [63:0] a);
`ifdef UNCACHE_MISALIGN_CHK_EN
    int n = 1 << sz[1:0];
    return (int'(a[2:0]) % n) != 0;
`else
    return (sz[0] & a[0]) & 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_strb(input logic [2:0] sz, input logic [63:0] a);
    int off = int'(a[2:0]);
    int n = 1 << sz[1:0];
    logic [7:0] s = '0;
    for (int i = 0; i < n; i++) if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] sz, input logic [63:0] a);
    logic [63:0] o = a - BASE;
    int off = int'(a[2:0]);
    int n = 1 << sz[1:0];
    int ba;
    logic [63:0] r = '0;
    if (is_mis(sz, a)) return '1;
    if (!in_rng(a)) return '0;
    ba = int'(o[AW+2:0]);
    for (int i = 0; i < n; i++) if (off + i < 8) r[i*8 +: 8] = ref_a[ba+i];
    return r;
  endfunction

  task automatic ref_store(input logic [2:0] sz, input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] o = a - BASE;
    int off = int'(a[2:0]);
    int n = 1 << sz[1:0];
    int ba;
    if (is_mis(sz, a) || !in_rng(a)) return;
    ba = int'(o[AW+2:0]);
    for (int i = 0; i < n; i++) if (off + i < 8) ref_a[ba+i] = wd[i*8 +: 8];
  endtask

  task automatic set_word(input int idx, input logic [63:0] val);
    bd_we = 1'b1; bd_idx = AW'(idx); bd_val = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
    for (int i = 0; i < 8; i++) ref_a[idx*8+i] = val[i*8 +: 8];
  endtask

  task automatic issue_a(input bit wr, input logic [2:0] sz, input logic [63:0] a,
                         input logic [63:0] wd);
    int t = 0;
    while (a_if.uncache_mem_ready_o !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    cmps++;
    if (t >= 40) begin
      errs++;
      $display("FAIL ready_wait: ready=%b required 1", a_if.uncache_mem_ready_o);
    end
    a_if.uncache_mem_vld_i = 1'b1; a_if.uncache_mem_write_i = wr;
    a_if.uncache_mem_size_i = sz; a_if.uncache_mem_addr_i = a; a_if.uncache_mem_wdata_i = wd;
    @(posedge clk); #1;
    // Scramble request fields after handshake; they must not affect the access.
    a_if.uncache_mem_vld_i = 1'b0; a_if.uncache_mem_write_i = 1'($urandom);
    a_if.uncache_mem_size_i = 3'($urandom); a_if.uncache_mem_addr_i = {$urandom, $urandom};
    a_if.uncache_mem_wdata_i = {$urandom, $urandom};
  endtask

  task automatic test_store_one(input logic [2:0] sz, input logic [63:0] a, input logic [63:0] wd,
                                output logic [7:0] strb_seen);
    logic [63:0] o = a - BASE;
    bit exp_wr = in_rng(a) && !is_mis(sz, a);
    int en_n = 0;
    int en_c = 0;
    logic we_s = 1'b0;
    logic [AW-1:0] ad_s = '0;
    logic [7:0] st_s = '0;
    logic [63:0] wd_s = '0;
    bit err_bad = 1'b0;
    logic [88+AW:0] got, exp;
    issue_a(1'b1, sz, a, wd);
    for (int c = 1; c <= LAT_A + 3; c++) begin
      @(negedge clk);
      if (sa_en) begin
        en_n++; en_c = c; we_s = sa_we; ad_s = sa_addr; st_s = sa_wstrb; wd_s = sa_wdata;
      end
`ifdef UNCACHE_MISALIGN_CHK_EN
      if (a_if.uncache_mem_err_o !== (is_mis(sz, a) && c == LAT_A + 2)) err_bad = 1'b1;
`endif
      if (c == LAT_A + 3) begin
        cmps++;
        if (a_if.uncache_mem_ready_o !== 1'b1) begin
          errs++;
          $display("FAIL store_ready_after: ready=%b required 1 addr=%h", a_if.uncache_mem_ready_o, a);
        end
      end
    end
    got = {8'(en_n), 8'(en_c), we_s, ad_s, st_s, wd_s};
    exp = exp_wr ? {8'd1, 8'(LAT_A + 2), 1'b1, o[AW+2:3], exp_strb(sz, a), wd << (8 * a[2:0])}
                 : '0;
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL store_access sz=%0d addr=%h: got %h required %h", sz, a, got, exp);
    end
`ifdef UNCACHE_MISALIGN_CHK_EN
    cmps++;
    if (err_bad) begin
      errs++;
      $display("FAIL store_err sz=%0d addr=%h: err pattern wrong, required pulse=%b", sz, a,
               is_mis(sz, a));
    end
`endif
    ref_store(sz, a, wd);
    strb_seen = st_s;
  endtask

  task automatic test_load_one(input logic [2:0] sz, input logic [63:0] a, input int hold,
                               output logic [63:0] data_seen);
    logic [63:0] o = a - BASE;
    logic [63:0] exp_d = ref_load(sz, a);
    bit exp_rd = in_rng(a) && !is_mis(sz, a);
    int en_n = 0;
    int en_c = 0;
    logic we_s = 1'b0;
    logic [AW-1:0] ad_s = '0;
    int vld_c = -1;
    bit unstable = 1'b0;
    bit err_bad = 1'b0;
    logic [16+AW:0] got, exp;
    a_if.uncache_mem_resp_rdy_i = 1'b0;
    issue_a(1'b0, sz, a, {$urandom, $urandom});
    for (int c = 1; c <= LAT_A + 8 && vld_c < 0; c++) begin
      @(negedge clk);
      if (sa_en) begin en_n++; en_c = c; we_s = sa_we; ad_s = sa_addr; end
      if (a_if.uncache_mem_resp_vld_o === 1'b1) vld_c = c;
    end
    data_seen = a_if.uncache_mem_resp_data_o;
    got = {8'(en_n), 8'(en_c), we_s, ad_s};
    exp = exp_rd ? {8'd1, 8'(LAT_A + 2), 1'b0, o[AW+2:3]} : '0;
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL load_access sz=%0d addr=%h: got %h required %h", sz, a, got, exp);
    end
    cmps++;
    if (vld_c != LAT_A + 4) begin
      errs++;
      $display("FAIL load_latency addr=%h: resp_vld at cycle %0d required %0d", a, vld_c, LAT_A + 4);
    end
    cmps++;
    if (data_seen !== exp_d) begin
      errs++;
      $display("FAIL load_data sz=%0d addr=%h: got %h required %h", sz, a, data_seen, exp_d);
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      if (a_if.uncache_mem_resp_vld_o !== 1'b1 || a_if.uncache_mem_resp_data_o !== data_seen)
        unstable = 1'b1;
`ifdef UNCACHE_MISALIGN_CHK_EN
      if (a_if.uncache_mem_err_o !== is_mis(sz, a)) err_bad = 1'b1;
`endif
    end
    if (hold > 0) begin
      cmps++;
      if (unstable) begin
        errs++;
        $display("FAIL load_hold addr=%h: vld=%b data=%h required 1 and %h", a,
                 a_if.uncache_mem_resp_vld_o, a_if.uncache_mem_resp_data_o, data_seen);
      end
    end
`ifdef UNCACHE_MISALIGN_CHK_EN
    cmps++;
    if (err_bad) begin
      errs++;
      $display("FAIL load_err addr=%h: err=%b required %b", a, a_if.uncache_mem_err_o,
               is_mis(sz, a));
    end
`endif
    a_if.uncache_mem_resp_rdy_i = 1'b1;
    @(posedge clk); #1;
    a_if.uncache_mem_resp_rdy_i = 1'b0;
    @(negedge clk);
    cmps++;
    if ({a_if.uncache_mem_ready_o, a_if.uncache_mem_resp_vld_o} !== 2'b10) begin
      errs++;
      $display("FAIL load_release addr=%h: ready,vld=%b%b required 10", a,
               a_if.uncache_mem_ready_o, a_if.uncache_mem_resp_vld_o);
    end
  endtask

  task automatic test_reset;
    logic [7:0] s;
    logic [145:0] got;
    int en_n = 0;
    test_store_one(3'd0, BASE + 64'h1d, {$urandom, $urandom}, s);
    issue_a(1'b1, 3'd3, BASE + 64'h20, 64'hdead_beef_cafe_f00d);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {a_if.uncache_mem_ready_o, sa_en, sa_we, sa_addr, sa_wstrb, sa_wdata,
           a_if.uncache_mem_resp_vld_o, a_if.uncache_mem_resp_data_o};
    cmps++;
    if (got !== {1'b1, 145'd0}) begin
      errs++;
      $display("FAIL reset_state: got %h required %h", got, {1'b1, 145'd0});
    end
`ifdef UNCACHE_MISALIGN_CHK_EN
    cmps++;
    if (a_if.uncache_mem_err_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_err: err=%b required 0", a_if.uncache_mem_err_o);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (sa_en) en_n++;
    end
    cmps++;
    if (en_n != 0 || a_if.uncache_mem_ready_o !== 1'b1) begin
      errs++;
      $display("FAIL reset_abandon: sram_en pulses=%0d ready=%b required 0 and 1", en_n,
               a_if.uncache_mem_ready_o);
    end
  endtask

  task automatic test_byte_store_dload;
    logic [7:0] s;
    logic [63:0] d;
    set_word(0, 64'h0);
    test_store_one(3'd0, BASE + 64'd5, 64'hab, s);
    cmps++;
    if (s !== 8'h20) begin
      errs++;
      $display("FAIL byte_strobe: got %h required 20", s);
    end
    test_load_one(3'd3, BASE, 0, d);
    cmps++;
    if (d !== 64'h0000_ab00_0000_0000) begin
      errs++;
      $display("FAIL byte_then_dword: got %h required 0000ab0000000000", d);
    end
  endtask

  task automatic test_half_hold;
    logic [63:0] d;
    set_word(1, 64'h1122_3344_5566_7788);
    test_load_one(3'd1, BASE + 64'd14, 3, d);
    cmps++;
    if (d !== 64'h1122) begin
      errs++;
      $display("FAIL half_off6: got %h required 1122", d);
    end
  endtask

  task automatic test_out_of_range;
    logic [63:0] d;
    logic [7:0] s;
    test_load_one(3'd3, BASE - 64'd8, 2, d);
    test_store_one(3'd3, BASE + 64'(SPAN), {$urandom, $urandom}, s);
    test_store_one(3'd2, BASE - 64'd4, {$urandom, $urandom}, s);
  endtask

  task automatic test_back_to_back;
    logic [63:0] w0 = {$urandom, $urandom};
    logic [63:0] d1 = {$urandom, $urandom};
    logic [63:0] d2 = {$urandom, $urandom};
    int rdy_c = -1;
    int e1 = 0;
    int e2 = 0;
    logic [7:0] st1 = '0;
    logic [7:0] st2 = '0;
    set_word(0, w0);
    @(negedge clk);
    b_if.uncache_mem_vld_i = 1'b1; b_if.uncache_mem_write_i = 1'b1;
    b_if.uncache_mem_size_i = 3'd2; b_if.uncache_mem_addr_i = BASE; b_if.uncache_mem_wdata_i = d1;
    @(posedge clk); #1;
    b_if.uncache_mem_addr_i = BASE + 64'd4; b_if.uncache_mem_wdata_i = d2;
    for (int c = 1; c <= 6 && rdy_c < 0; c++) begin
      @(negedge clk);
      if (sb_en) begin e1 = c; st1 = sb_wstrb; end
      if (b_if.uncache_mem_ready_o === 1'b1) rdy_c = c;
    end
    cmps++;
    if (rdy_c != 3 || e1 != 2 || st1 !== 8'h0f) begin
      errs++;
      $display("FAIL b2b_first: ready at %0d en at %0d strb %h required 3 2 0f", rdy_c, e1, st1);
    end
    @(posedge clk); #1;
    b_if.uncache_mem_vld_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (sb_en) begin e2 = c; st2 = sb_wstrb; end
    end
    cmps++;
    if (e2 != 2 || st2 !== 8'hf0) begin
      errs++;
      $display("FAIL b2b_second: en at %0d strb %h required 2 f0", e2, st2);
    end
    cmps++;
    if (mem_b[0] !== {d2[31:0], d1[31:0]}) begin
      errs++;
      $display("FAIL b2b_merge: got %h required %h", mem_b[0], {d2[31:0], d1[31:0]});
    end
  endtask

  task automatic test_misalign;
    logic [63:0] d;
    logic [7:0] s;
`ifdef UNCACHE_MISALIGN_CHK_EN
    test_load_one(3'd2, BASE + 64'd2, 1, d);
    cmps++;
    if (d !== 64'hffff_ffff_ffff_ffff) begin
      errs++;
      $display("FAIL misalign_load: got %h required ffffffffffffffff", d);
    end
    test_store_one(3'd3, BASE + 64'd9, {$urandom, $urandom}, s);
`else
    test_store_one(3'd2, BASE + 64'd6, {$urandom, $urandom}, s);
    cmps++;
    if (s !== 8'hc0) begin
      errs++;
      $display("FAIL misalign_strobe: got %h required c0", s);
    end
    test_load_one(3'd3, BASE + 64'd3, 0, d);
`endif
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic [7:0] s;
    logic [63:0] a;
    for (int n = 0; n < 150; n++) begin
      a = BASE - 64'd16 + 64'($urandom_range(0, SPAN + 31));
      if ($urandom_range(0, 1) == 1) test_store_one(3'($urandom), a, {$urandom, $urandom}, s);
      else test_load_one(3'($urandom), a, int'($urandom_range(0, 3)), d);
    end
    for (int w = 0; w < WORDS; w++) test_load_one(3'd3, BASE + 64'(w * 8), 0, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.uncache_mem_vld_i = 1'b0; a_if.uncache_mem_write_i = 1'b0; a_if.uncache_mem_size_i = '0;
    a_if.uncache_mem_addr_i = '0; a_if.uncache_mem_wdata_i = '0; a_if.uncache_mem_resp_rdy_i = 1'b0;
    b_if.uncache_mem_vld_i = 1'b0; b_if.uncache_mem_write_i = 1'b0; b_if.uncache_mem_size_i = '0;
    b_if.uncache_mem_addr_i = '0; b_if.uncache_mem_wdata_i = '0; b_if.uncache_mem_resp_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < WORDS; w++) set_word(w, {$urandom, $urandom});
    @(negedge clk);
    test_reset();
    test_byte_store_dload();
    test_half_hold();
    test_out_of_range();
    test_back_to_back();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
